// File: rtl/ram_ctrl_sync_if.sv
// MOV/MOC request bundle for the data RAM controller.
// Master is the control unit, slave is ram_ctrl_sync.
interface ram_ctrl_sync_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  MOV;
  logic                  ReadWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           DataIn;
  logic [5:0]            OP;
  logic [31:0]           DataOut;
  logic                  MOC;
  logic                  Err;

  modport master (
    output MOV, ReadWrite, Address, DataIn, OP,
    input  DataOut, MOC, Err
  );

  modport slave (
    input  MOV, ReadWrite, Address, DataIn, OP,
    output DataOut, MOC, Err
  );
endinterface

// File: rtl/ram_ctrl_sync.sv
// Big-endian byte-addressed data RAM with registered MOV/MOC
// handshake, wait states, signed loads and two-phase LDD/STD.
module ram_ctrl_sync #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            reset,
  ram_ctrl_sync_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            op_q;
  logic                  rw_q;
  logic [31:0]           din_q;
  logic [3:0]            cnt;
  logic                  phase;
  logic [31:0]           dout_q;
  logic                  moc_q;
  logic                  err_q;

  logic                  vld, is_ld, dw, sgn;
  logic [1:0]            sz;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic                  mis, err, fire;
  logic [31:0]           ldata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    unique case (state)
      IDLE: if (bus.MOV) state_nx = WAIT;
      WAIT: if (cnt == 4'd0) begin
        state_nx = DONE;
        fire     = 1'b1;
      end
      DONE: if (!bus.MOV) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // sz: 0 byte, 1 half, 2 word (dword transfers one word per phase)
  always_comb begin
    vld   = 1'b1;
    is_ld = 1'b0;
    dw    = 1'b0;
    sgn   = 1'b0;
    sz    = 2'd2;
    unique case (op_q)
      6'b001000: is_ld = 1'b1;
      6'b000010: begin is_ld = 1'b1; sz = 2'd1; end
      6'b000001: begin is_ld = 1'b1; sz = 2'd0; end
      6'b001010: begin
        is_ld = 1'b1; sz = 2'd1; sgn = 1'b1;
      end
      6'b001001: begin
        is_ld = 1'b1; sz = 2'd0; sgn = 1'b1;
      end
      6'b000011: begin is_ld = 1'b1; dw = 1'b1; end
      6'b000100: ;
      6'b000110: sz = 2'd1;
      6'b000101: sz = 2'd0;
      6'b000111: dw = 1'b1;
      default:   vld = 1'b0;
    endcase
  end

  assign a0 = phase ? addr_q + ADDR_WIDTH'(4) : addr_q;
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  assign mis = (sz == 2'd2 && a0[1:0] != 2'b00)
             | (sz == 2'd1 && a0[0])
             | (dw && !phase && a0[2]);
  assign err = !vld || (is_ld != rw_q) || mis;

  always_comb begin
    ldata = {b0, b1, b2, b3};
    unique case (sz)
      2'd0: ldata = {{24{sgn & b0[7]}}, b0};
      2'd1: ldata = {{16{sgn & b0[7]}}, b0, b1};
      default: ldata = {b0, b1, b2, b3};
    endcase
  end

  // Memory is never reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && fire && !err && !is_ld) begin
      unique case (sz)
        2'd0: mem[a0] <= din_q[7:0];
        2'd1: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        default: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      op_q   <= '0;
      rw_q   <= 1'b0;
      din_q  <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      dout_q <= '0;
      moc_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.MOV) begin
          din_q <= bus.DataIn;
          cnt   <= 4'(WAIT_STATES);
          if (!phase) begin
            addr_q <= bus.Address;
            op_q   <= bus.OP;
            rw_q   <= bus.ReadWrite;
          end
        end
        WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          moc_q <= 1'b1;
          err_q <= err;
          if (!err && is_ld) dout_q <= ldata;
        end
        DONE: if (!bus.MOV) begin
          moc_q <= 1'b0;
          err_q <= 1'b0;
          phase <= !phase && dw && !err_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.Err     = err_q;
endmodule

// File: tb/tb_ram_ctrl_sync.sv
// Scoreboard bench for ram_ctrl_sync: WAIT_STATES=1 and =0 instances
// checked against a byte-array model of the memory rules.
module tb_ram_ctrl_sync;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        mov = 1'b0;
  logic        rw = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] din = '0;
  logic [5:0]  op = '0;
  int          sel = 0;

  ram_ctrl_sync_if #(.ADDR_WIDTH(9)) b1 ();
  ram_ctrl_sync_if #(.ADDR_WIDTH(9)) b0 ();

  ram_ctrl_sync #(.ADDR_WIDTH(9), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  ram_ctrl_sync #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  assign b1.MOV       = mov && sel == 0;
  assign b0.MOV       = mov && sel == 1;
  assign b1.ReadWrite = rw;
  assign b0.ReadWrite = rw;
  assign b1.Address   = addr;
  assign b0.Address   = addr;
  assign b1.DataIn    = din;
  assign b0.DataIn    = din;
  assign b1.OP        = op;
  assign b0.OP        = op;

  wire        moc  = sel == 1 ? b0.MOC : b1.MOC;
  wire        merr = sel == 1 ? b0.Err : b1.Err;
  wire [31:0] dout = sel == 1 ? b0.DataOut : b1.DataOut;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  logic moc_prev = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (!reset && moc && !moc_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_moc", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("mon_dataout", dout, x.d);
        chk("mon_err", {31'd0, merr}, {31'd0, x.e});
      end
    end
    moc_prev = moc;
  end

  // Reference model: byte array per instance plus dword phase state.
  logic [7:0]  mm [2][512];
  logic [31:0] mdo [2];
  bit          mph [2];
  logic [8:0]  mpa [2];
  logic [5:0]  mpo [2];
  logic        mprw [2];

  task automatic model(input int s, input logic r, input logic [8:0] a,
                       input logic [5:0] o, input logic [31:0] d,
                       output logic e, output logic [31:0] dd);
    logic [8:0]  ea;
    logic [5:0]  eo;
    logic        er;
    logic [31:0] v;
    int n, al;
    bit ok, ld, dw, sg;
    if (mph[s]) begin
      ea = mpa[s] + 9'd4; eo = mpo[s]; er = mprw[s];
    end else begin
      ea = a; eo = o; er = r;
    end
    ok = 1; ld = 0; dw = 0; sg = 0; n = 4;
    case (eo)
      6'b001000: ld = 1;
      6'b000010: begin ld = 1; n = 2; end
      6'b000001: begin ld = 1; n = 1; end
      6'b001010: begin ld = 1; n = 2; sg = 1; end
      6'b001001: begin ld = 1; n = 1; sg = 1; end
      6'b000011: begin ld = 1; dw = 1; end
      6'b000100: ;
      6'b000110: n = 2;
      6'b000101: n = 1;
      6'b000111: dw = 1;
      default:   ok = 0;
    endcase
    al = (dw && !mph[s]) ? 8 : n;
    e = !ok || (ld != er) || (int'(ea) % al != 0);
    if (!e) begin
      if (ld) begin
        v = 0;
        for (int k = 0; k < n; k++)
          v = (v << 8) | 32'(mm[s][ea + 9'(k)]);
        if (sg && n == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
        mdo[s] = v;
      end else begin
        for (int k = 0; k < n; k++)
          mm[s][ea + 9'(k)] = 8'(d >> (8 * (n - 1 - k)));
      end
    end
    if (!mph[s] && dw && !e) begin
      mph[s] = 1; mpa[s] = a; mpo[s] = o; mprw[s] = r;
    end else begin
      mph[s] = 0;
    end
    dd = mdo[s];
  endtask

  task automatic txn(input int s, input logic r, input logic [8:0] a,
                     input logic [5:0] o, input logic [31:0] d,
                     input int hold);
    exp_t x;
    int n;
    bit seen;
    model(s, r, a, o, d, x.e, x.d);
    sb.push_back(x);
    sel = s; rw = r; addr = a; op = o; din = d; mov = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (moc) seen = 1;
    end
    if (!seen) chk("moc_timeout", 32'd0, 32'd1);
    else chk("latency", 32'(n), s == 0 ? 32'd3 : 32'd2);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("moc_hold", {31'd0, moc}, 32'd1);
    end
    mov = 1'b0;
    @(posedge clk); #1;
    chk("moc_drop", {30'd0, moc, merr}, 32'd0);
  endtask

  localparam logic [5:0] LD = 6'b001000, LDUH = 6'b000010;
  localparam logic [5:0] LDUB = 6'b000001, LDSH = 6'b001010;
  localparam logic [5:0] LDSB = 6'b001001, LDD = 6'b000011;
  localparam logic [5:0] ST = 6'b000100, STH = 6'b000110;
  localparam logic [5:0] STB = 6'b000101, STD = 6'b000111;

  initial begin
    logic [5:0] ops [10];
    int oi, sz, a;
    logic r;
    logic [5:0] o;
    ops = '{LD, LDUH, LDUB, LDSH, LDSB, LDD, ST, STH, STB, STD};
    for (int s = 0; s < 2; s++) begin
      mdo[s] = 0; mph[s] = 0; mpa[s] = 0; mpo[s] = 0; mprw[s] = 0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_dut1", {b1.DataOut[30:0], b1.MOC | b1.Err}, 32'd0);
    chk("rst_dut0", {b0.DataOut[30:0], b0.MOC | b0.Err}, 32'd0);
    chk("rst_dout_msb", {30'd0, b1.DataOut[31], b0.DataOut[31]}, 32'd0);

    txn(0, 0, 9'h000, ST, 32'hAE910F2B, 0);
    txn(0, 1, 9'h000, LD, 32'h0, 1);
    chk("ld_word", dout, 32'hAE910F2B);
    txn(0, 0, 9'h004, STH, 32'h0000AABB, 0);
    txn(0, 1, 9'h004, LDUH, 32'h0, 0);
    chk("lduh", dout, 32'h0000AABB);
    txn(0, 1, 9'h004, LDSH, 32'h0, 0);
    chk("ldsh", dout, 32'hFFFFAABB);
    txn(0, 0, 9'h006, STB, 32'h00000055, 0);
    txn(0, 1, 9'h006, LDSB, 32'h0, 0);
    chk("ldsb", dout, 32'h00000055);
    txn(0, 1, 9'h004, LDUB, 32'h0, 0);
    chk("ldub", dout, 32'h000000AA);

    txn(0, 1, 9'h002, LD, 32'h0, 0);
    txn(0, 1, 9'h000, 6'b111111, 32'h0, 0);
    txn(0, 1, 9'h000, ST, 32'h12345678, 0);
    chk("err_dout_kept", dout, 32'h000000AA);
    txn(0, 1, 9'h000, LD, 32'h0, 0);
    chk("err_mem_kept", dout, 32'hAE910F2B);

    txn(0, 0, 9'h008, STD, 32'h11111111, 0);
    txn(0, 1, 9'h100, LDUB, 32'h22222222, 0);
    txn(0, 1, 9'h008, LDD, 32'h0, 0);
    chk("ldd_p0", dout, 32'h11111111);
    txn(0, 0, 9'h055, ST, 32'h0, 0);
    chk("ldd_p1", dout, 32'h22222222);

    txn(0, 0, 9'h1FC, ST, 32'hDEADBEEF, 0);
    txn(0, 0, 9'h1FF, STB, 32'h00000077, 0);
    txn(0, 1, 9'h1FC, LD, 32'h0, 0);
    chk("top_word", dout, 32'hDEADBE77);

    txn(0, 0, 9'h010, ST, 32'h12345678, 0);
    sel = 0; rw = 0; addr = 9'h010; op = ST;
    din = 32'hCAFEF00D; mov = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; mov = 1'b0;
    @(posedge clk); #1;
    chk("abort_moc_dout", {b1.DataOut[30:0], b1.MOC}, 32'd0);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mdo[s] = 0; mph[s] = 0;
    end
    txn(0, 1, 9'h010, LD, 32'h0, 0);
    chk("abort_no_write", dout, 32'h12345678);

    txn(1, 0, 9'h020, ST, 32'hA5A55A5A, 0);
    txn(1, 1, 9'h020, LD, 32'h0, 3);
    chk("ws0_ld", dout, 32'hA5A55A5A);
    txn(1, 1, 9'h022, LDSH, 32'h0, 2);
    chk("ws0_ldsh", dout, 32'h00005A5A);

    for (int i = 0; i < 16; i++)
      txn(0, 0, 9'(4 * i), ST, $urandom, 0);
    for (int i = 0; i < 200; i++) begin
      oi = $urandom_range(0, 9);
      o = ops[oi];
      r = oi < 6;
      if ($urandom_range(0, 19) == 0) o = 6'($urandom);
      if ($urandom_range(0, 19) == 0) r = !r;
      sz = (o == LDD || o == STD) ? 8 :
           (o == LDUH || o == LDSH || o == STH) ? 2 :
           (o == LDUB || o == LDSB || o == STB) ? 1 : 4;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 4) != 0) a = a - (a % sz);
      txn(0, r, 9'(a), o, $urandom, $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
